// File: rtl/vga_timing_monitor.sv
// vga_timing_monitor
// Receive-side checker for generated VGA timing. Samples hSync/vSync on each
// pixel strobe, rebuilds the horizontal/vertical counters, locks after a run of
// well-formed frames and decodes which grid cell the beam is currently inside.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high
//   pix_en       one-cycle pixel strobe; every sample/update happens only here
//   hSync        active-high line sync
//   vSync        active-high frame sync
//   locked       timing verified, hc_rec/vc_rec trustworthy
//   hc_rec       recovered horizontal count, 0..H_TOTAL-1
//   vc_rec       recovered vertical count, 0..V_TOTAL-1
//   in_cell      locked and beam inside the grid area
//   cell_col     grid column under the beam (0 when !in_cell)
//   cell_row     grid row under the beam (0 when !in_cell)
//   frame_start  one-sample pulse at (0,0) while staying locked
//   err          one-sample pulse on a timing violation while locked
//   err_count    violations seen while locked since reset, saturating at 255

module vga_timing_monitor #(
    parameter int H_TOTAL     = 800,
    parameter int H_SYNC      = 96,
    parameter int V_TOTAL     = 525,
    parameter int V_SYNC      = 2,
    parameter int GRID_X0     = 255,
    parameter int GRID_Y0     = 66,
    parameter int CELL        = 30,
    parameter int CELLS       = 14,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_en,
    input  logic       hSync,
    input  logic       vSync,
    output logic       locked,
    output logic [9:0] hc_rec,
    output logic [9:0] vc_rec,
    output logic       in_cell,
    output logic [3:0] cell_col,
    output logic [3:0] cell_row,
    output logic       frame_start,
    output logic       err,
    output logic [7:0] err_count
);

    localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNC_W  = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_W  = 10'(V_SYNC);
    localparam logic [9:0] X0        = 10'(GRID_X0);
    localparam logic [9:0] Y0        = 10'(GRID_Y0);
    localparam logic [9:0] CELL_LAST = 10'(CELL - 1);
    localparam logic [3:0] IDX_LAST  = 4'(CELLS - 1);
    localparam logic [3:0] LOCK_LAST = 4'(LOCK_FRAMES - 1);

    typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

    state_t     state;
    logic       h_prev;
    logic       v_prev;
    logic [9:0] h_width;
    logic [9:0] v_width;
    logic [3:0] good_frames;
    logic [9:0] x_sub;
    logic [9:0] y_sub;
    logic [3:0] col_cnt;
    logic [3:0] row_cnt;
    logic       in_x;
    logic       in_y;

    logic       h_rise;
    logic       h_fall;
    logic       v_rise;
    logic       v_fall;
    logic       frame_edge;
    logic       violation;
    logic [9:0] hc_next;
    logic [9:0] vc_next;
    logic [9:0] x_sub_next;
    logic [9:0] y_sub_next;
    logic [3:0] col_next;
    logic [3:0] row_next;
    logic       in_x_next;
    logic       in_y_next;
    logic       cell_hit;
    logic [3:0] col_hit;
    logic [3:0] row_hit;

    assign h_rise     = hSync & ~h_prev;
    assign h_fall     = ~hSync & h_prev;
    assign v_rise     = vSync & ~v_prev;
    assign v_fall     = ~vSync & v_prev;
    assign frame_edge = h_rise & v_rise;

    // Counters only restart through a sync edge; past the last position they
    // hold, and the missing-sync check below reports it.
    always_comb begin
        hc_next = hc_rec;
        if (h_rise) begin
            hc_next = '0;
        end else if (hc_rec != H_LAST) begin
            hc_next = hc_rec + 10'd1;
        end

        vc_next = vc_rec;
        if (frame_edge) begin
            vc_next = '0;
        end else if (h_rise && (vc_rec != V_LAST)) begin
            vc_next = vc_rec + 10'd1;
        end
    end

    // All violation sources are judged against the previous sample's counts
    // and collapse into one flag, so a sample breaking several rules counts once.
    always_comb begin
        violation = 1'b0;
        if (h_rise && (hc_rec != H_LAST))                violation = 1'b1;
        if (!h_rise && (hc_rec == H_LAST))               violation = 1'b1;
        if (h_fall && (h_width != H_SYNC_W))             violation = 1'b1;
        if (v_rise && (!h_rise || (vc_rec != V_LAST)))   violation = 1'b1;
        if (h_rise && !v_rise && (vc_rec == V_LAST))     violation = 1'b1;
        if (v_fall && (v_width != V_SYNC_W))             violation = 1'b1;
    end

    // Cell tracking walks sub-pixel and sub-line counters instead of dividing.
    // The grid-origin match is tested first so an origin at 0 still works.
    always_comb begin
        in_x_next  = in_x;
        x_sub_next = x_sub;
        col_next   = col_cnt;
        if (hc_next == X0) begin
            in_x_next  = 1'b1;
            x_sub_next = '0;
            col_next   = '0;
        end else if (h_rise) begin
            in_x_next  = 1'b0;
            x_sub_next = '0;
            col_next   = '0;
        end else if (in_x) begin
            if (x_sub == CELL_LAST) begin
                x_sub_next = '0;
                if (col_cnt == IDX_LAST) begin
                    in_x_next = 1'b0;
                    col_next  = '0;
                end else begin
                    col_next = col_cnt + 4'd1;
                end
            end else begin
                x_sub_next = x_sub + 10'd1;
            end
        end

        in_y_next  = in_y;
        y_sub_next = y_sub;
        row_next   = row_cnt;
        if (h_rise) begin
            if (vc_next == Y0) begin
                in_y_next  = 1'b1;
                y_sub_next = '0;
                row_next   = '0;
            end else if (frame_edge) begin
                in_y_next  = 1'b0;
                y_sub_next = '0;
                row_next   = '0;
            end else if (in_y) begin
                if (y_sub == CELL_LAST) begin
                    y_sub_next = '0;
                    if (row_cnt == IDX_LAST) begin
                        in_y_next = 1'b0;
                        row_next  = '0;
                    end else begin
                        row_next = row_cnt + 4'd1;
                    end
                end else begin
                    y_sub_next = y_sub + 10'd1;
                end
            end
        end

        cell_hit = in_x_next & in_y_next;
        col_hit  = cell_hit ? col_next : 4'd0;
        row_hit  = cell_hit ? row_next : 4'd0;
    end

    // Lock FSM plus every registered output. Outputs default to their idle
    // values on each strobe and are only driven active by the locked paths,
    // which is what makes err/frame_start single-sample pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= SEARCH;
            h_prev      <= 1'b0;
            v_prev      <= 1'b0;
            h_width     <= '0;
            v_width     <= '0;
            good_frames <= '0;
            x_sub       <= '0;
            y_sub       <= '0;
            col_cnt     <= '0;
            row_cnt     <= '0;
            in_x        <= 1'b0;
            in_y        <= 1'b0;
            locked      <= 1'b0;
            hc_rec      <= '0;
            vc_rec      <= '0;
            in_cell     <= 1'b0;
            cell_col    <= '0;
            cell_row    <= '0;
            frame_start <= 1'b0;
            err         <= 1'b0;
            err_count   <= '0;
        end else if (pix_en) begin
            h_prev  <= hSync;
            v_prev  <= vSync;
            hc_rec  <= hc_next;
            vc_rec  <= vc_next;
            x_sub   <= x_sub_next;
            y_sub   <= y_sub_next;
            col_cnt <= col_next;
            row_cnt <= row_next;
            in_x    <= in_x_next;
            in_y    <= in_y_next;

            // hSync width in pixels, vSync width in lines started/seen.
            if (h_rise) begin
                h_width <= 10'd1;
            end else if (hSync && (h_width != 10'h3FF)) begin
                h_width <= h_width + 10'd1;
            end
            if (v_rise) begin
                v_width <= 10'd1;
            end else if (vSync && h_rise && (v_width != 10'h3FF)) begin
                v_width <= v_width + 10'd1;
            end

            locked      <= 1'b0;
            in_cell     <= 1'b0;
            cell_col    <= '0;
            cell_row    <= '0;
            frame_start <= 1'b0;
            err         <= 1'b0;

            case (state)
                SEARCH: begin
                    if (frame_edge) begin
                        state       <= CHECK;
                        good_frames <= '0;
                    end
                end
                CHECK: begin
                    if (violation) begin
                        state <= SEARCH;
                    end else if (frame_edge) begin
                        if (good_frames == LOCK_LAST) begin
                            state    <= LOCKED;
                            locked   <= 1'b1;
                            in_cell  <= cell_hit;
                            cell_col <= col_hit;
                            cell_row <= row_hit;
                        end else begin
                            good_frames <= good_frames + 4'd1;
                        end
                    end
                end
                LOCKED: begin
                    if (violation) begin
                        state <= SEARCH;
                        err   <= 1'b1;
                        if (err_count != 8'hFF) begin
                            err_count <= err_count + 8'd1;
                        end
                    end else begin
                        locked      <= 1'b1;
                        in_cell     <= cell_hit;
                        cell_col    <= col_hit;
                        cell_row    <= row_hit;
                        frame_start <= frame_edge;
                    end
                end
                default: begin
                    state <= SEARCH;
                end
            endcase
        end
    end

endmodule
